lkroute_pipe: RTL and testbench

LKROUTE_PIPE -- requirements
Module: lkroute_pipe

---
 rtl/lkroute_pkg.sv | 18 +
 rtl/lkroute_dir_calc.sv | 42 ++++
 rtl/lkroute_pipe.sv | 167 ++++++++++++++++
 tb/tb_lkroute_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lkroute_pkg.sv
// lkroute_pkg: port encodings and sizing helpers shared by the lookahead router pipeline
package lkroute_pkg;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_WEST  = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    // ceil(log2(n)), never below 1 so a single-router dimension still gets a wire
    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/lkroute_dir_calc.sv
// lkroute_dir_calc: direction to take at router (i_x,i_y) to reach (i_dx,i_dy)
//   i_x, i_y   : router coordinates
//   i_dx, i_dy : destination coordinates
//   o_dir      : output port (LOCAL when arrived)
module lkroute_dir_calc
    import lkroute_pkg::*;
#(
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter string TOPOLOGY   = "MESH",
    parameter string ROUTE_NAME = "XY",
    localparam int   RXw        = log2(NX),
    localparam int   RYw        = log2(NY)
)(
    input  logic [RXw-1:0] i_x,
    input  logic [RYw-1:0] i_y,
    input  logic [RXw-1:0] i_dx,
    input  logic [RYw-1:0] i_dy,
    output logic [2:0]     o_dir
);

    localparam bit IS_TORUS = (TOPOLOGY == "TORUS");
    localparam bit IS_YX    = (ROUTE_NAME == "YX");

    int         w_dist_x;
    int         w_dist_y;
    logic [2:0] w_dir_x;
    logic [2:0] w_dir_y;

    // forward ring distance; a tie at exactly half the ring goes EAST/SOUTH
    assign w_dist_x = (int'(i_dx) >= int'(i_x)) ? int'(i_dx) - int'(i_x) : int'(i_dx) + NX - int'(i_x);
    assign w_dist_y = (int'(i_dy) >= int'(i_y)) ? int'(i_dy) - int'(i_y) : int'(i_dy) + NY - int'(i_y);

    assign w_dir_x = IS_TORUS ? ((w_dist_x == 0) ? P_LOCAL : (w_dist_x <= NX / 2) ? P_EAST : P_WEST)
                              : ((i_dx > i_x) ? P_EAST : (i_dx < i_x) ? P_WEST : P_LOCAL);
    assign w_dir_y = IS_TORUS ? ((w_dist_y == 0) ? P_LOCAL : (w_dist_y <= NY / 2) ? P_SOUTH : P_NORTH)
                              : ((i_dy > i_y) ? P_SOUTH : (i_dy < i_y) ? P_NORTH : P_LOCAL);

    assign o_dir = IS_YX ? ((w_dir_y != P_LOCAL) ? w_dir_y : w_dir_x)
                         : ((w_dir_x != P_LOCAL) ? w_dir_x : w_dir_y);

endmodule

// File: rtl/lkroute_pipe.sv
// lkroute_pipe: two-stage lookahead route computation (next-router port) with DfD trace
//   clk, reset                  : clock, synchronous active-high reset
//   current_rx, current_ry      : this router's coordinates
//   in_valid/in_ready           : request handshake; in_dest_e_addr={ey,ex}, in_destport, in_tag
//   out_valid/out_ready         : result handshake; out_lkdestport, out_tag, out_err
//   trigger, trace              : pulse after an illegal request is accepted; counters/last-error word
module lkroute_pipe
    import lkroute_pkg::*;
#(
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter string TOPOLOGY   = "MESH",
    parameter string ROUTE_NAME = "XY",
    parameter int    TAGw       = 2,
    localparam int   RXw        = log2(NX),
    localparam int   RYw        = log2(NY),
    localparam int   EAw        = RXw + RYw
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [RXw-1:0]  current_rx,
    input  logic [RYw-1:0]  current_ry,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EAw-1:0]  in_dest_e_addr,
    input  logic [2:0]      in_destport,
    input  logic [TAGw-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_lkdestport,
    output logic [TAGw-1:0] out_tag,
    output logic            out_err,
    output logic            trigger,
    output logic [31:0]     trace
);

    localparam bit             IS_TORUS = (TOPOLOGY == "TORUS");
    localparam logic [RXw-1:0] X_MAX    = RXw'(NX - 1);
    localparam logic [RYw-1:0] Y_MAX    = RYw'(NY - 1);

    logic [RXw-1:0]  w_ex;
    logic [RYw-1:0]  w_ey;
    logic            w_ex_ok;
    logic            w_ey_ok;
    logic [RXw-1:0]  w_nx;
    logic [RYw-1:0]  w_ny;
    logic            w_off_edge;
    logic            w_illegal;
    logic            w_s2_load;
    logic            w_accept;
    logic [2:0]      w_dir;

    logic            r_s1_valid;
    logic [RXw-1:0]  r_s1_nx;
    logic [RYw-1:0]  r_s1_ny;
    logic [RXw-1:0]  r_s1_ex;
    logic [RYw-1:0]  r_s1_ey;
    logic [TAGw-1:0] r_s1_tag;
    logic            r_s1_err;
    logic            r_s2_valid;
    logic [2:0]      r_s2_port;
    logic [TAGw-1:0] r_s2_tag;
    logic            r_s2_err;
    logic            r_trigger;
    logic [15:0]     r_acc_cnt;
    logic [7:0]      r_err_cnt;
    logic [2:0]      r_last_err_port;
    logic [1:0]      r_last_err_ok;

    assign w_ex    = in_dest_e_addr[RXw-1:0];
    assign w_ey    = in_dest_e_addr[EAw-1:RXw];
    assign w_ex_ok = int'(w_ex) < NX;
    assign w_ey_ok = int'(w_ey) < NY;

    // coordinates always wrap; in a mesh a wrapping step is flagged illegal instead
    assign w_nx = (in_destport == P_EAST) ? ((current_rx == X_MAX) ? '0 : current_rx + 1'b1)
                : (in_destport == P_WEST) ? ((current_rx == '0) ? X_MAX : current_rx - 1'b1)
                : current_rx;
    assign w_ny = (in_destport == P_SOUTH) ? ((current_ry == Y_MAX) ? '0 : current_ry + 1'b1)
                : (in_destport == P_NORTH) ? ((current_ry == '0) ? Y_MAX : current_ry - 1'b1)
                : current_ry;

    assign w_off_edge = !IS_TORUS && ((in_destport == P_EAST  && current_rx == X_MAX) ||
                                      (in_destport == P_WEST  && current_rx == '0)    ||
                                      (in_destport == P_NORTH && current_ry == '0)    ||
                                      (in_destport == P_SOUTH && current_ry == Y_MAX));

    assign w_illegal = !w_ex_ok || !w_ey_ok || (in_destport > P_SOUTH) || w_off_edge ||
                       (in_destport == P_LOCAL && (w_ex != current_rx || w_ey != current_ry));

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !reset && (!r_s1_valid || w_s2_load);
    assign w_accept  = in_valid && in_ready;

    lkroute_dir_calc #(
        .NX         (NX),
        .NY         (NY),
        .TOPOLOGY   (TOPOLOGY),
        .ROUTE_NAME (ROUTE_NAME)
    ) u_dir_calc (
        .i_x   (r_s1_nx),
        .i_y   (r_s1_ny),
        .i_dx  (r_s1_ex),
        .i_dy  (r_s1_ey),
        .o_dir (w_dir)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_nx    <= '0;
            r_s1_ny    <= '0;
            r_s1_ex    <= '0;
            r_s1_ey    <= '0;
            r_s1_tag   <= '0;
            r_s1_err   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_port  <= P_LOCAL;
            r_s2_tag   <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                r_s1_nx    <= w_nx;
                r_s1_ny    <= w_ny;
                r_s1_ex    <= w_ex;
                r_s1_ey    <= w_ey;
                r_s1_tag   <= in_tag;
                r_s1_err   <= w_illegal;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                r_s2_port  <= r_s1_err ? P_LOCAL : w_dir;
                r_s2_tag   <= r_s1_tag;
                r_s2_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trigger       <= 1'b0;
            r_acc_cnt       <= '0;
            r_err_cnt       <= '0;
            r_last_err_port <= '0;
            r_last_err_ok   <= '0;
        end else begin
            r_trigger <= w_accept && w_illegal;
            if (w_accept)
                r_acc_cnt <= (&r_acc_cnt) ? r_acc_cnt : r_acc_cnt + 1'b1;
            if (w_accept && w_illegal) begin
                r_err_cnt       <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
                r_last_err_port <= in_destport;
                r_last_err_ok   <= {w_ex_ok, w_ey_ok};
            end
        end
    end

    // outputs are forced quiet for the whole reset window, not just after the first edge
    assign out_valid      = !reset && r_s2_valid;
    assign out_lkdestport = reset ? P_LOCAL : r_s2_port;
    assign out_tag        = reset ? '0 : r_s2_tag;
    assign out_err        = !reset && r_s2_err;
    assign trigger        = !reset && r_trigger;
    assign trace          = reset ? '0 : {r_err_cnt, r_acc_cnt, r_last_err_port, r_last_err_ok, 3'b000};

endmodule

// File: tb/tb_lkroute_pipe.sv
// tb_lkroute_pipe: table-driven scoreboard bench over MESH-XY, MESH-YX and TORUS-XY instances in lockstep
module tb_lkroute_pipe;

    typedef struct {
        logic [1:0] cx, cy, ex, ey;
        logic [2:0] dp;
        logic [2:0] e_mxy, e_myx, e_txy;
        logic       err_m, err_t;
    } vec_t;

    typedef struct {
        logic [2:0] p0, p1, p2;
        logic       e0, e1;
        logic [1:0] tag;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  current_rx, current_ry;
    logic        in_valid;
    logic [3:0]  in_dest_e_addr;
    logic [2:0]  in_destport;
    logic [1:0]  in_tag;
    logic        out_ready;
    logic [2:0]  ir, ov, trg, oer;
    logic [2:0]  op  [3];
    logic [1:0]  otg [3];
    logic [31:0] trc [3];

    vec_t vt [16];
    exp_t sb [$];
    int   n_cmp = 0, n_bad = 0, n_pop = 0, ncyc = 0, cur_idx = 0;
    bit   lat_on = 1'b0;
    logic       exp_trig = 1'b0;
    logic [7:0] m_err = '0;
    logic [15:0] m_acc = '0;
    logic [2:0] m_lp = '0;
    logic [1:0] m_ok = '0;

    always #5 clk = ~clk;

    lkroute_pipe #(.TOPOLOGY("MESH"), .ROUTE_NAME("XY")) u_mxy (
        .clk(clk), .reset(reset), .current_rx(current_rx), .current_ry(current_ry),
        .in_valid(in_valid), .in_ready(ir[0]), .in_dest_e_addr(in_dest_e_addr),
        .in_destport(in_destport), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
        .out_lkdestport(op[0]), .out_tag(otg[0]), .out_err(oer[0]), .trigger(trg[0]), .trace(trc[0]));

    lkroute_pipe #(.TOPOLOGY("MESH"), .ROUTE_NAME("YX")) u_myx (
        .clk(clk), .reset(reset), .current_rx(current_rx), .current_ry(current_ry),
        .in_valid(in_valid), .in_ready(ir[1]), .in_dest_e_addr(in_dest_e_addr),
        .in_destport(in_destport), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready),
        .out_lkdestport(op[1]), .out_tag(otg[1]), .out_err(oer[1]), .trigger(trg[1]), .trace(trc[1]));

    lkroute_pipe #(.TOPOLOGY("TORUS"), .ROUTE_NAME("XY")) u_txy (
        .clk(clk), .reset(reset), .current_rx(current_rx), .current_ry(current_ry),
        .in_valid(in_valid), .in_ready(ir[2]), .in_dest_e_addr(in_dest_e_addr),
        .in_destport(in_destport), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready),
        .out_lkdestport(op[2]), .out_tag(otg[2]), .out_err(oer[2]), .trigger(trg[2]), .trace(trc[2]));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic vec_t mk(int cx, int cy, int ex, int ey, int dp, int pm, int py, int pt, int em, int et);
        vec_t v;
        v.cx = 2'(cx); v.cy = 2'(cy); v.ex = 2'(ex); v.ey = 2'(ey); v.dp = 3'(dp);
        v.e_mxy = 3'(pm); v.e_myx = 3'(py); v.e_txy = 3'(pt);
        v.err_m = (em != 0); v.err_t = (et != 0);
        return v;
    endfunction

    task automatic drive(input int idx);
        cur_idx        = idx;
        current_rx     = vt[idx].cx;
        current_ry     = vt[idx].cy;
        in_dest_e_addr = {vt[idx].ey, vt[idx].ex};
        in_destport    = vt[idx].dp;
        in_tag         = 2'(idx);
    endtask

    // streams vectors back-to-back, dropping out_ready on cycles slo..shi, then drains
    task automatic run(input int first, input int n, input int slo, input int shi, input bit lat);
        int i = 0;
        lat_on = lat;
        for (int c = 0; c < 100 && i < n; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= slo && c <= shi);
            in_valid  = 1'b1;
            drive(first + i);
            @(negedge clk);
            if (ir[0]) i++;
        end
        if (i < n) chk("accept_timeout", 32'(i), 32'(n));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) @(posedge clk);
        chk("drain", 32'(sb.size()), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (reset) begin
            chk("rst_in_ready", 32'(ir), 0);
            chk("rst_out_valid", 32'(ov), 0);
            chk("rst_trigger", 32'(trg), 0);
            chk("rst_trace", trc[0], 0);
            chk("rst_port", 32'(op[0]), 0);
            chk("rst_tag", 32'(otg[0]), 0);
            chk("rst_err", 32'(oer), 0);
            exp_trig = 1'b0; m_acc = '0; m_err = '0; m_lp = '0; m_ok = '0;
        end else begin
            chk("trigger", 32'(trg[0]), 32'(exp_trig));
            chk("trace", trc[0], {m_err, m_acc, m_lp, m_ok, 3'b000});
            exp_trig = 1'b0;
            if (in_valid && ir[0]) begin
                e.p0 = vt[cur_idx].e_mxy; e.p1 = vt[cur_idx].e_myx; e.p2 = vt[cur_idx].e_txy;
                e.e0 = vt[cur_idx].err_m; e.e1 = vt[cur_idx].err_t;
                e.tag = 2'(cur_idx); e.t = ncyc;
                sb.push_back(e);
                m_acc++;
                if (vt[cur_idx].err_m) begin
                    exp_trig = 1'b1; m_err++; m_lp = vt[cur_idx].dp; m_ok = 2'b11;
                end
            end
            if (ov[0] && out_ready) begin
                if (sb.size() == 0) chk("spurious_out_valid", 32'(ov[0]), 0);
                else begin
                    e = sb.pop_front();
                    n_pop++;
                    chk("valid_all", 32'(ov), 7);
                    chk("port_mesh_xy", 32'(op[0]), 32'(e.p0));
                    chk("port_mesh_yx", 32'(op[1]), 32'(e.p1));
                    chk("port_torus_xy", 32'(op[2]), 32'(e.p2));
                    chk("err_mesh_xy", 32'(oer[0]), 32'(e.e0));
                    chk("err_mesh_yx", 32'(oer[1]), 32'(e.e0));
                    chk("err_torus", 32'(oer[2]), 32'(e.e1));
                    chk("tag", 32'(otg[0]), 32'(e.tag));
                    chk("tag_torus", 32'(otg[2]), 32'(e.tag));
                    if (lat_on) chk("latency", 32'(ncyc - e.t), 2);
                end
            end
        end
    end

    initial begin
        int n0;
        //           cx cy ex ey dp  mxy myx txy  em et
        vt[0]  = mk(1, 1, 3, 2, 1,  1, 4, 1,  0, 0);
        vt[1]  = mk(1, 1, 2, 1, 1,  0, 0, 0,  0, 0);
        vt[2]  = mk(1, 1, 2, 3, 1,  4, 4, 4,  0, 0);
        vt[3]  = mk(3, 0, 1, 0, 1,  0, 0, 1,  1, 0);
        vt[4]  = mk(3, 0, 2, 0, 1,  0, 0, 1,  1, 0);
        vt[5]  = mk(2, 2, 0, 0, 3,  3, 2, 3,  0, 0);
        vt[6]  = mk(0, 0, 0, 3, 2,  0, 0, 0,  1, 0);
        vt[7]  = mk(1, 2, 1, 0, 2,  2, 2, 2,  0, 0);
        vt[8]  = mk(2, 2, 2, 2, 0,  0, 0, 0,  0, 0);
        vt[9]  = mk(2, 2, 3, 2, 0,  0, 0, 0,  1, 1);
        vt[10] = mk(1, 1, 1, 1, 5,  0, 0, 0,  1, 1);
        vt[11] = mk(0, 3, 3, 3, 4,  0, 0, 3,  1, 0);
        vt[12] = mk(1, 0, 0, 2, 4,  3, 4, 3,  0, 0);
        vt[13] = mk(0, 1, 3, 1, 3,  0, 0, 0,  1, 0);
        vt[14] = mk(3, 3, 0, 0, 3,  3, 2, 1,  0, 0);
        vt[15] = mk(2, 1, 2, 3, 4,  4, 4, 4,  0, 0);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run(0, 16, -1, -1, 1'b1);

        @(posedge clk); #1 reset = 1'b1; sb.delete();
        @(posedge clk); #1 reset = 1'b0;
        run(0, 8, 3, 5, 1'b0);
        chk("acc_cnt_8", 32'(trc[0][23:8]), 8);
        chk("err_cnt_3", 32'(trc[0][31:24]), 3);

        @(posedge clk); #1 reset = 1'b1; sb.delete();
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive(k);
            in_valid = 1'b1;
            @(negedge clk);
            chk("inflight_accept", 32'(ir[0]), 1);
        end
        @(posedge clk); #1;
        chk("inflight_valid", 32'(ov[0]), 1);
        in_valid = 1'b0; reset = 1'b1; sb.delete();
        n0 = n_pop;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1; lat_on = 1'b1;
        drive(8);
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_after_reset", 32'(ir[0]), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        chk("no_stale", 32'(n_pop - n0), 1);
        chk("drain_after_reset", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
